// File: rtl/loop_count_ctl_pkg.sv
// rtl/loop_count_ctl_pkg.sv - shared types and constants for the loop counter sequencer
// Purpose: slice width, command/SEL opcode encoding and sequencer state type.
// Ports: none (package).
package loop_count_ctl_pkg;

   localparam int SLICE_W = 4;

   // Command opcodes share their encoding with the per-slice SEL code.
   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_DEC  = 2'b01,
      OP_INC  = 2'b10,
      OP_HOLD = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

endpackage

// File: rtl/loop_count_ctl_if.sv
// rtl/loop_count_ctl_if.sv - command/status bundle for loop_count_ctl
// Purpose: groups the command handshake, step/abort controls and counter status.
// Ports (signals): cmd_valid/cmd_ready/cmd_op/cmd_data command handshake; step_en, abort run controls;
//   count, slice_sel, slice_cout, busy, done status; count_par when LOOP_COUNT_CTL_PARITY_EN is defined.
// Modports: master drives commands (requester), slave is the loop_count_ctl side.
interface loop_count_ctl_if
   import loop_count_ctl_pkg::*;
   #(parameter int WIDTH = 12) ();

   localparam int NSLICE = WIDTH / SLICE_W;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [WIDTH-1:0]      cmd_data;
   logic                  step_en;
   logic                  abort;
   logic [WIDTH-1:0]      count;
   logic [2*NSLICE-1:0]   slice_sel;
   logic [NSLICE-1:0]     slice_cout;
   logic                  busy;
   logic                  done;
`ifdef LOOP_COUNT_CTL_PARITY_EN
   logic                  count_par;
`endif

   modport master (
      output cmd_valid, cmd_op, cmd_data, step_en, abort,
      input  cmd_ready, count, slice_sel, slice_cout, busy, done
`ifdef LOOP_COUNT_CTL_PARITY_EN
      , input count_par
`endif
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, step_en, abort,
      output cmd_ready, count, slice_sel, slice_cout, busy, done
`ifdef LOOP_COUNT_CTL_PARITY_EN
      , output count_par
`endif
   );

endinterface

// File: rtl/loop_count_slice.sv
// rtl/loop_count_slice.sv - 4-bit up/down counter slice with carry-in enable
// Purpose: one nibble of the loop counter; LOAD/DEC/INC/HOLD selected by sel.
// Ports: CLK, RESET (async, active-high, clears to 0); sel SEL code; cin step enable;
//   d load value; q slice value; cout terminal/carry indication for the next slice.
module loop_count_slice
   import loop_count_ctl_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET,
   input  op_t                sel,
   input  logic               cin,
   input  logic [SLICE_W-1:0] d,
   output logic [SLICE_W-1:0] q,
   output logic               cout
);

   localparam logic [SLICE_W-1:0] ONE = 1;

   logic [SLICE_W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      case (sel)
         OP_LOAD: q_d = d;
         OP_DEC:  if (cin) q_d = q_q - ONE;
         OP_INC:  if (cin) q_d = q_q + ONE;
         default: q_d = q_q;
      endcase
   end

   // cout does not include cin; the parent ANDs the chain itself.
   always_comb begin
      cout = 1'b0;
      case (sel)
         OP_LOAD: cout = 1'b1;
         OP_DEC:  cout = (q_q == '0);
         OP_INC:  cout = (q_q == '1);
         default: cout = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/loop_count_ctl.sv
// rtl/loop_count_ctl.sv - loop counter sequencer built from 4-bit up/down slices
// Purpose: accepts LOAD/DEC-run/INC-run/HOLD commands, steps the sliced counter one count per
//   enabled cycle until terminal (0 for DEC, all-ones for INC), reports done; abort ends a run silently.
// Ports: CLK; RESET (async, active-high); bus (loop_count_ctl_if.slave) carrying the command
//   handshake, step_en/abort, count, slice_sel, slice_cout, busy, done.
// Option: LOOP_COUNT_CTL_PARITY_EN adds bus.count_par = ~^count.
module loop_count_ctl
   import loop_count_ctl_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input logic              CLK,
   input logic              RESET,
   loop_count_ctl_if.slave  bus
);

   localparam int NSLICE = WIDTH / SLICE_W;

   state_t state_q, state_d;
   op_t    run_op_q, run_op_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;
   logic   ready_q, ready_d;

   logic [WIDTH-1:0]  count;
   logic [NSLICE-1:0] carry;
   logic [NSLICE-1:0] cout;
   op_t               cmd_op;
   op_t               sel;
   logic              accept;
   logic              terminal;

   assign cmd_op   = op_t'(bus.cmd_op);
   assign accept   = bus.cmd_valid & ready_q;
   assign terminal = (run_op_q == OP_DEC) ? (count == '0) : (count == '1);

   // All slices share one SEL: run direction while running, load on the LOAD accept cycle.
   always_comb begin
      sel = OP_HOLD;
      if (state_q == S_RUN)
         sel = run_op_q;
      else if (accept && (cmd_op == OP_LOAD))
         sel = OP_LOAD;
   end

   // Abort and terminal both suppress the step so count holds its pre-edge value.
   assign carry[0] = bus.step_en & (state_q == S_RUN) & ~bus.abort & ~terminal;

   for (genvar i = 0; i < NSLICE; i++) begin : g_slice
      loop_count_slice u_slice (
         .CLK  (CLK),
         .RESET(RESET),
         .sel  (sel),
         .cin  (carry[i]),
         .d    (bus.cmd_data[i*SLICE_W +: SLICE_W]),
         .q    (count[i*SLICE_W +: SLICE_W]),
         .cout (cout[i])
      );
      if (i < NSLICE - 1) begin : g_ripple
         assign carry[i+1] = carry[i] & cout[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      run_op_d = run_op_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if ((cmd_op == OP_DEC) || (cmd_op == OP_INC)) begin
                  state_d  = S_RUN;
                  run_op_d = cmd_op;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (bus.abort)    state_d = S_IDLE;
            else if (terminal) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Outputs decode the next state so they are registered alongside it.
      busy_d  = (state_d == S_RUN);
      done_d  = (state_d == S_DONE);
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         run_op_q <= OP_HOLD;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         run_op_q <= run_op_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
      end
   end

   assign bus.cmd_ready  = ready_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.count      = count;
   assign bus.slice_sel  = {NSLICE{sel}};
   assign bus.slice_cout = cout;

`ifdef LOOP_COUNT_CTL_PARITY_EN
   // count is itself a flop output, so this changes on the same edge as count.
   assign bus.count_par = ~^count;
`endif

endmodule

// File: tb/tb_loop_count_ctl.sv
// tb/tb_loop_count_ctl.sv - self-checking bench for loop_count_ctl
module tb_loop_count_ctl;
   import loop_count_ctl_pkg::*;

   localparam int WIDTH  = 12;
   localparam int NSLICE = 3;
   localparam int MAXV   = 4095;
   localparam int GUARD  = 20000;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   loop_count_ctl_if #(.WIDTH(WIDTH)) bus ();
   loop_count_ctl #(.WIDTH(WIDTH)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: 0 idle, 1 running, 2 done; mode 1 = down, 2 = up.
   int m_state = 0;
   int m_count = 0;
   int m_mode  = 1;

   typedef struct {
      logic [11:0] load_val;
      logic [1:0]  op;
      bit          toggle;
      int          abort_at;
      int          exp_count;
      int          exp_steps;
      bit          exp_done;
      int          exp_busy;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_state = 0;
      m_count = 0;
      m_mode  = 1;
   endtask

   task automatic model_step();
      case (m_state)
         0: if (bus.cmd_valid) begin
               case (int'(bus.cmd_op))
                  0: begin m_count = int'(bus.cmd_data); m_state = 2; end
                  3: m_state = 2;
                  default: begin m_mode = int'(bus.cmd_op); m_state = 1; end
               endcase
            end
         1: begin
               if (bus.abort) m_state = 0;
               else if ((m_mode == 1 && m_count == 0) || (m_mode == 2 && m_count == MAXV)) m_state = 2;
               else if (bus.step_en) m_count = (m_mode == 1) ? m_count - 1 : m_count + 1;
            end
         default: m_state = 0;
      endcase
      m_count = m_count & MAXV;
   endtask

   task automatic check_pre();
      int es;
      int ec;
      int nib;
      es = 3;
      if (m_state == 1) es = m_mode;
      else if (m_state == 0 && bus.cmd_valid && bus.cmd_op == 2'b00) es = 0;
      for (int i = 0; i < NSLICE; i++) begin
         nib = (m_count >> (4 * i)) & 15;
         case (es)
            0: ec = 1;
            1: ec = (nib == 0) ? 1 : 0;
            2: ec = (nib == 15) ? 1 : 0;
            default: ec = 0;
         endcase
         check($sformatf("slice_sel[%0d]", i), int'(bus.slice_sel[2*i +: 2]), es);
         check($sformatf("slice_cout[%0d]", i), int'(bus.slice_cout[i]), ec);
      end
   endtask

   task automatic check_post();
      logic [11:0] mc;
      mc = m_count[11:0];
      check("count", int'(bus.count), m_count);
      check("busy", int'(bus.busy), (m_state == 1) ? 1 : 0);
      check("done", int'(bus.done), (m_state == 2) ? 1 : 0);
      check("cmd_ready", int'(bus.cmd_ready), (m_state == 0) ? 1 : 0);
`ifdef LOOP_COUNT_CTL_PARITY_EN
      check("count_par", int'(bus.count_par), int'(~^mc));
`else
      mc = '0;
`endif
   endtask

   task automatic cycle();
      #1;
      check_pre();
      @(posedge CLK);
      model_step();
      #1;
      check_post();
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [11:0] data);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      bus.step_en   = 1'b0;
      bus.abort     = 1'b0;
      cycle();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   steps, busy_c, guard;
      bit   done_s, phase;
      logic [11:0] prev;
      v = vecs[idx];
      send_cmd(2'b00, v.load_val);
      cycle();
      send_cmd(v.op, 12'h000);
      steps = 0; busy_c = 0; guard = 0; done_s = 0; phase = 1'b1;
      while (m_state != 0 && guard < GUARD) begin
         guard++;
         if (bus.busy) busy_c++;
         if (bus.done) done_s = 1'b1;
         bus.step_en = v.toggle ? phase : 1'b1;
         phase = ~phase;
         bus.abort = (v.abort_at >= 0 && m_state == 1 && m_count == v.abort_at);
         prev = bus.count;
         cycle();
         if (bus.count != prev) steps++;
      end
      bus.abort   = 1'b0;
      bus.step_en = 1'b0;
      check($sformatf("v%0d_timeout", idx), (guard < GUARD) ? 1 : 0, 1);
      check($sformatf("v%0d_count", idx), int'(bus.count), v.exp_count);
      check($sformatf("v%0d_steps", idx), steps, v.exp_steps);
      check($sformatf("v%0d_done", idx), int'(done_s), int'(v.exp_done));
      if (v.exp_busy >= 0) check($sformatf("v%0d_busy_cycles", idx), busy_c, v.exp_busy);
   endtask

   initial begin
      int guard;
      vecs[0] = '{12'h0A5, 2'b11, 1'b0, -1, 'h0A5, 0,     1'b1, 0};
      vecs[1] = '{12'h003, 2'b01, 1'b0, -1, 0,     3,     1'b1, 4};
      vecs[2] = '{12'h0FE, 2'b10, 1'b1, -1, 'hFFF, 'hF01, 1'b1, -1};
      vecs[3] = '{12'h000, 2'b01, 1'b0, -1, 0,     0,     1'b1, 1};
      vecs[4] = '{12'h005, 2'b01, 1'b0, 2,  2,     3,     1'b0, 4};
      vecs[5] = '{12'h002, 2'b01, 1'b0, 0,  0,     2,     1'b0, 3};
      vecs[6] = '{12'h000, 2'b01, 1'b0, 0,  0,     0,     1'b0, 1};
      vecs[7] = '{12'hFFF, 2'b10, 1'b0, -1, 'hFFF, 0,     1'b1, 1};
      vecs[8] = '{12'h010, 2'b01, 1'b1, -1, 0,     16,    1'b1, -1};
      vecs[9] = '{12'hFF0, 2'b10, 1'b0, -1, 'hFFF, 15,    1'b1, 16};

      RESET = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b11;
      bus.cmd_data  = '0;
      bus.step_en   = 1'b0;
      bus.abort     = 1'b0;
      model_reset();
      #3;
      check("reset_count", int'(bus.count), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_ready", int'(bus.cmd_ready), 1);
      check("reset_sel", int'(bus.slice_sel), 'h3F);
      @(negedge CLK);
      RESET = 1'b0;
      @(posedge CLK);
      #1;

      for (int i = 0; i < 10; i++) run_vec(i);

      // Command offered while busy must wait, then be taken once idle.
      send_cmd(2'b00, 12'h004);
      cycle();
      send_cmd(2'b01, 12'h000);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_data  = 12'h777;
      bus.step_en   = 1'b1;
      guard = 0;
      while (m_state != 0 && guard < 100) begin
         guard++;
         cycle();
      end
      check("held_timeout", (guard < 100) ? 1 : 0, 1);
      check("held_not_taken", int'(bus.count), 0);
      cycle();
      bus.cmd_valid = 1'b0;
      bus.step_en   = 1'b0;
      cycle();
      check("held_cmd_loaded", int'(bus.count), 'h777);

      // Asynchronous reset in the middle of a run.
      send_cmd(2'b00, 12'h130);
      cycle();
      send_cmd(2'b01, 12'h000);
      bus.step_en = 1'b1;
      guard = 0;
      while (m_count != 'h123 && guard < 100) begin
         guard++;
         cycle();
      end
      check("midrun_count", int'(bus.count), 'h123);
      check("midrun_busy", int'(bus.busy), 1);
      #2;
      RESET = 1'b1;
      #1;
      check("arst_count", int'(bus.count), 0);
      check("arst_busy", int'(bus.busy), 0);
      check("arst_ready", int'(bus.cmd_ready), 1);
      check("arst_done", int'(bus.done), 0);
`ifdef LOOP_COUNT_CTL_PARITY_EN
      check("arst_par", int'(bus.count_par), 1);
`endif
      model_reset();
      bus.step_en = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      @(posedge CLK);
      #1;

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         bus.cmd_valid = ($urandom % 2) == 0;
         bus.cmd_op    = 2'($urandom % 4);
         bus.cmd_data  = 12'($urandom);
         bus.step_en   = ($urandom % 4) != 0;
         bus.abort     = ($urandom % 8) == 0;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
